// File: rtl/sid_voice_scheduler_if.sv
// Register-write bus into the SID voice scheduler.
//   wr_valid : host has a write this cycle
//   wr_ready : scheduler accepts the write this cycle
//   wr_addr  : {voice[4:3], reg[2:0]}
//   wr_data  : byte to write
interface sid_voice_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/sid_voice_scheduler.sv
// SID voice scheduler: holds VOICES config banks, and on each sample_tick it
// time-multiplexes the shared voice datapath over the banks (one slot per
// voice). It then sums the returned samples into mix_out.
//   clk, rst_n        : clock, async active-low reset
//   wr (slave)        : register write bus, ready only outside service slots
//   sample_tick       : request one output sample
//   frequency..wave   : config of the voice being serviced (held between slots)
//   voice_sel/strobe  : serviced voice index / high in every slot cycle
//   voice_in          : scaled sample returned for the serviced voice
//   mix_out/mix_valid : summed sample, one-cycle valid pulse
//   overrun           : sticky, a tick was dropped
module sid_voice_scheduler #(
  parameter int VOICES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sid_voice_scheduler_if.slave wr,
  input  logic                 sample_tick,
  output logic [15:0]          frequency,
  output logic [7:0]           duration,
  output logic [7:0]           attack,
  output logic [7:0]           sustain,
  output logic [7:0]           waveform,
  output logic [1:0]           voice_sel,
  output logic                 voice_strobe,
  input  logic [7:0]           voice_in,
  output logic [9:0]           mix_out,
  output logic                 mix_valid,
  output logic                 overrun
);
  typedef enum logic [1:0] {IDLE, SLOT, MIX} state_e;

  localparam logic [2:0] NUM_V     = 3'(VOICES);
  localparam logic [1:0] LAST_SLOT = 2'(VOICES - 1);

  state_e state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic pend_q, pend_d, ovr_q, ovr_d;
  logic [9:0] acc_q, acc_d, mix_out_q, mix_out_d;
  logic mix_valid_q, mix_valid_d, wr_ready_q, wr_ready_d;
  logic voice_strobe_q, voice_strobe_d;
  logic [1:0] voice_sel_q, voice_sel_d;
  logic [15:0] frequency_q, frequency_d;
  logic [7:0] duration_q, duration_d, attack_q, attack_d;
  logic [7:0] sustain_q, sustain_d, waveform_q, waveform_d;

  logic [VOICES-1:0][15:0] freq_q, freq_d;
  logic [VOICES-1:0][7:0]  stage_q, stage_d, dur_q, dur_d, wave_q, wave_d;
  logic [VOICES-1:0][7:0]  att_q, att_d, sus_q, sus_d;

  logic [1:0] wr_voice;
  logic       wr_fire;
  logic       idle_start;

  always_comb begin
    freq_d = freq_q;  stage_d = stage_q; dur_d = dur_q;
    wave_d = wave_q;  att_d   = att_q;   sus_d = sus_q;
    state_d = state_q; slot_d = slot_q; pend_d = pend_q; ovr_d = ovr_q;
    acc_d = acc_q; mix_out_d = mix_out_q; mix_valid_d = 1'b0;
    voice_strobe_d = 1'b0; voice_sel_d = voice_sel_q;
    frequency_d = frequency_q; duration_d = duration_q; attack_d = attack_q;
    sustain_d = sustain_q; waveform_d = waveform_q;
    idle_start = 1'b0;

    // Writes to absent voices or reserved regs handshake but change nothing.
    wr_voice = wr.wr_addr[4:3];
    wr_fire  = wr.wr_valid && wr_ready_q && ({1'b0, wr_voice} < NUM_V);
    if (wr_fire) begin
      case (wr.wr_addr[2:0])
        3'd0: stage_d[wr_voice] = wr.wr_data;
        // Frequency commits as a whole word so a half-updated value is never seen.
        3'd1: freq_d[wr_voice]  = {wr.wr_data, stage_q[wr_voice]};
        3'd2: dur_d[wr_voice]   = wr.wr_data;
        3'd3: wave_d[wr_voice]  = wr.wr_data;
        3'd4: att_d[wr_voice]   = wr.wr_data;
        3'd5: sus_d[wr_voice]   = wr.wr_data;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (sample_tick || pend_q) begin
          idle_start = 1'b1;
          state_d = SLOT;
          slot_d  = 2'd0;
          acc_d   = 10'd0;
          // Consuming a pending tick while a fresh one arrives re-arms pending.
          pend_d  = pend_q && sample_tick;
        end
      end
      SLOT: begin
        acc_d = acc_q + {2'b00, voice_in};
        if (slot_q == LAST_SLOT) state_d = MIX;
        else                     slot_d  = slot_q + 2'd1;
      end
      MIX: begin
        mix_out_d   = acc_q;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!idle_start && state_q != IDLE && sample_tick) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    // Outputs are registered from the next state; bank values come from the
    // _d side so a write coinciding with the starting tick is presented.
    if (state_d == SLOT) begin
      voice_strobe_d = 1'b1;
      voice_sel_d    = slot_d;
      frequency_d    = freq_d[slot_d];
      duration_d     = dur_d[slot_d];
      waveform_d     = wave_d[slot_d];
      attack_d       = att_d[slot_d];
      sustain_d      = sus_d[slot_d];
    end
    wr_ready_d = (state_d != SLOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; slot_q <= '0; pend_q <= 1'b0; ovr_q <= 1'b0;
      acc_q <= '0; mix_out_q <= '0; mix_valid_q <= 1'b0; wr_ready_q <= 1'b1;
      voice_strobe_q <= 1'b0; voice_sel_q <= '0;
      frequency_q <= '0; duration_q <= '0; attack_q <= '0;
      sustain_q <= '0; waveform_q <= '0;
      freq_q <= '0; stage_q <= '0; dur_q <= '0;
      wave_q <= '0; att_q <= '0; sus_q <= '0;
    end else begin
      state_q <= state_d; slot_q <= slot_d; pend_q <= pend_d; ovr_q <= ovr_d;
      acc_q <= acc_d; mix_out_q <= mix_out_d; mix_valid_q <= mix_valid_d;
      wr_ready_q <= wr_ready_d;
      voice_strobe_q <= voice_strobe_d; voice_sel_q <= voice_sel_d;
      frequency_q <= frequency_d; duration_q <= duration_d; attack_q <= attack_d;
      sustain_q <= sustain_d; waveform_q <= waveform_d;
      freq_q <= freq_d; stage_q <= stage_d; dur_q <= dur_d;
      wave_q <= wave_d; att_q <= att_d; sus_q <= sus_d;
    end
  end

  assign wr.wr_ready   = wr_ready_q;
  assign frequency     = frequency_q;
  assign duration      = duration_q;
  assign attack        = attack_q;
  assign sustain       = sustain_q;
  assign waveform      = waveform_q;
  assign voice_sel     = voice_sel_q;
  assign voice_strobe  = voice_strobe_q;
  assign mix_out       = mix_out_q;
  assign mix_valid     = mix_valid_q;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_sid_voice_scheduler.sv
module tb_sid_voice_scheduler;
  localparam int V = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sid_voice_scheduler_if wif();
  logic        sample_tick;
  logic [7:0]  voice_in;
  logic [15:0] frequency;
  logic [7:0]  duration, attack, sustain, waveform;
  logic [1:0]  voice_sel;
  logic        voice_strobe, mix_valid, overrun;
  logic [9:0]  mix_out;

  sid_voice_scheduler #(.VOICES(V)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wif.slave), .sample_tick(sample_tick),
    .frequency(frequency), .duration(duration), .attack(attack),
    .sustain(sustain), .waveform(waveform), .voice_sel(voice_sel),
    .voice_strobe(voice_strobe), .voice_in(voice_in), .mix_out(mix_out),
    .mix_valid(mix_valid), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: register contents plus sequence timing by cycle number.
  logic [15:0] m_freq [4];
  logic [7:0]  m_stage [4], m_dur [4], m_wave [4], m_att [4], m_sus [4];
  bit          seq_valid, m_pend, m_ovr;
  int          start, m_acc;
  logic [9:0]  m_mix;
  logic [1:0]  l_sel;
  logic [15:0] l_freq;
  logic [7:0]  l_dur, l_wave, l_att, l_sus;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_freq[i] = '0; m_stage[i] = '0; m_dur[i] = '0;
      m_wave[i] = '0; m_att[i] = '0; m_sus[i] = '0;
    end
    seq_valid = 0; m_pend = 0; m_ovr = 0; start = 0; m_acc = 0; m_mix = '0;
    l_sel = '0; l_freq = '0; l_dur = '0; l_wave = '0; l_att = '0; l_sus = '0;
  endtask

  task automatic mwrite(input logic [4:0] a, input logic [7:0] d);
    int v;
    v = int'(a[4:3]);
    if (v < V) begin
      case (a[2:0])
        3'd0: m_stage[v] = d;
        3'd1: m_freq[v]  = {d, m_stage[v]};
        3'd2: m_dur[v]   = d;
        3'd3: m_wave[v]  = d;
        3'd4: m_att[v]   = d;
        3'd5: m_sus[v]   = d;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance model.
  task automatic step(input bit wv, input logic [4:0] a, input logic [7:0] d,
                      input bit tk, input logic [7:0] vin);
    int ph;
    bit in_slot, in_mix, idle;
    @(posedge clk); #1;
    cyc++;
    ph      = seq_valid ? cyc - start : 0;
    in_slot = seq_valid && ph >= 1 && ph <= V;
    in_mix  = seq_valid && ph == V + 1;
    if (in_slot) begin
      l_sel = 2'(ph - 1);
      l_freq = m_freq[ph-1]; l_dur = m_dur[ph-1]; l_wave = m_wave[ph-1];
      l_att = m_att[ph-1];   l_sus = m_sus[ph-1];
    end
    chk("wr_ready", wif.wr_ready, !in_slot);
    chk("voice_strobe", voice_strobe, in_slot);
    chk("voice_sel", voice_sel, l_sel);
    chk("frequency", frequency, l_freq);
    chk("duration", duration, l_dur);
    chk("waveform", waveform, l_wave);
    chk("attack", attack, l_att);
    chk("sustain", sustain, l_sus);
    chk("mix_valid", mix_valid, seq_valid && ph == V + 2);
    chk("mix_out", mix_out, m_mix);
    chk("overrun", overrun, m_ovr);

    wif.wr_valid = wv; wif.wr_addr = a; wif.wr_data = d;
    sample_tick = tk; voice_in = vin;

    if (wv && !in_slot) mwrite(a, d);
    if (in_slot) m_acc += int'(vin);
    if (in_mix) m_mix = 10'(m_acc);
    idle = !in_slot && !in_mix;
    if (idle && (tk || m_pend)) begin
      seq_valid = 1; start = cyc; m_acc = 0; m_pend = m_pend && tk;
    end else if (!idle && tk) begin
      if (m_pend) m_ovr = 1;
      else        m_pend = 1;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 5'h0, 8'h0, 0, 8'h0);
  endtask

  task automatic rand_steps(input int n, input int tick_div);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 2) == 0, 5'($urandom), 8'($urandom),
           $urandom_range(0, tick_div - 1) == 0, 8'($urandom));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freq"}, frequency, 0);
    chk({tag, "_dur"}, duration, 0);
    chk({tag, "_att"}, attack, 0);
    chk({tag, "_sus"}, sustain, 0);
    chk({tag, "_wave"}, waveform, 0);
    chk({tag, "_sel"}, voice_sel, 0);
    chk({tag, "_strobe"}, voice_strobe, 0);
    chk({tag, "_mixv"}, mix_valid, 0);
    chk({tag, "_mixo"}, mix_out, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_ready"}, wif.wr_ready, 1);
  endtask

  initial begin
    wif.wr_valid = 0; wif.wr_addr = '0; wif.wr_data = '0;
    sample_tick = 0; voice_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk) rst_n = 1;

    // Staged lo alone leaves frequency untouched.
    step(1, 5'h00, 8'h34, 0, 0);
    step(0, 5'h00, 8'h00, 1, 0);
    step(0, 5'h00, 8'h00, 0, 0);
    chk("lo_only_freq", frequency, 16'h0000);
    idle_steps(6);

    // lo then hi commits the word.
    step(1, 5'h00, 8'h34, 0, 0);
    step(1, 5'h01, 8'h12, 0, 0);
    step(0, 5'h00, 8'h00, 1, 0);
    step(0, 5'h00, 8'h00, 0, 0);
    chk("freq_commit", frequency, 16'h1234);
    idle_steps(6);

    // Write coinciding with the tick is presented in SLOT(0).
    step(1, 5'h02, 8'h77, 1, 0);
    step(0, 5'h00, 8'h00, 0, 0);
    chk("coincide_dur", duration, 8'h77);
    idle_steps(6);

    // Absent voice and reserved reg: accepted, discarded.
    step(1, 5'h1B, 8'hAA, 0, 0);
    chk("absent_ready", wif.wr_ready, 1);
    step(1, 5'h06, 8'hBB, 0, 0);
    chk("resv_ready", wif.wr_ready, 1);
    step(0, 5'h00, 8'h00, 1, 0);
    step(0, 5'h00, 8'h00, 0, 0);
    chk("resv_freq", frequency, 16'h1234);
    chk("resv_dur", duration, 8'h77);
    idle_steps(6);

    // Full-scale mix and latency.
    step(0, 5'h00, 8'h00, 1, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      step(0, 5'h00, 8'h00, 0, 8'hFF);
      if (k <= 3) chk("busy_ready", wif.wr_ready, 0);
      if (k == 4) chk("mixv_early", mix_valid, 0);
      if (k == 5) begin
        chk("mixv_lat", mix_valid, 1);
        chk("mix_full", mix_out, 10'h2FD);
      end
    end
    idle_steps(6);

    // Back-to-back ticks: one pending, one dropped.
    step(0, 5'h00, 8'h00, 1, 8'h01);
    step(0, 5'h00, 8'h00, 1, 8'h01);
    step(0, 5'h00, 8'h00, 1, 8'h01);
    chk("ovr_before", overrun, 0);
    for (int k = 3; k <= 10; k++) begin
      step(0, 5'h00, 8'h00, 0, 8'h01);
      if (k == 3) chk("ovr_set", overrun, 1);
      if (k == 5) chk("mixv_first", mix_valid, 1);
      if (k == 6) chk("second_strobe", voice_strobe, 1);
      if (k == 10) chk("mixv_second", mix_valid, 1);
    end
    idle_steps(6);

    rand_steps(400, 6);
    idle_steps(12);

    // Reset during SLOT(1).
    step(0, 5'h00, 8'h00, 1, 8'h10);
    step(0, 5'h00, 8'h00, 0, 8'h10);
    step(0, 5'h00, 8'h00, 0, 8'h10);
    chk("pre_rst_sel", voice_sel, 1);
    #1 rst_n = 0;
    #1 chk_all_zero("midrst");
    model_reset();
    repeat (2) begin
      @(posedge clk); #1 chk("rst_no_mixv", mix_valid, 0);
    end
    @(negedge clk) rst_n = 1;
    step(0, 5'h00, 8'h00, 1, 8'h0A);
    for (int k = 1; k <= 5; k++) step(0, 5'h00, 8'h00, 0, 8'h0A);
    chk("post_rst_mixv", mix_valid, 1);
    chk("post_rst_mix", mix_out, 10'd30);

    rand_steps(200, 4);
    idle_steps(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sid_voice_scheduler.md
SID_VOICE_SCHEDULER -- requirements
Module: sid_voice_scheduler

Interface
REQ-001 SHALL have parameter: VOICES, default 3, number of voice register banks serviced (legal 1..4).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: wr_valid  input  1  register write request.
REQ-005 SHALL have port: wr_ready  output  1  scheduler can accept a write this cycle.
REQ-006 SHALL have port: wr_addr  input  5  {voice[4:3], reg[2:0]}.
REQ-007 SHALL have port: wr_data  input  8  write data.
REQ-008 SHALL have port: sample_tick  input  1  one-cycle request for one output sample.
REQ-009 SHALL have ports: frequency output 16, duration output 8, attack output 8, sustain output 8, waveform output 8; these carry the config of the voice being serviced.
REQ-010 SHALL have port: voice_sel  output  2  index of the voice being serviced.
REQ-011 SHALL have port: voice_strobe  output  1  high during every service-slot cycle.
REQ-012 SHALL have port: voice_in  input  8  envelope-scaled voice sample returned by the shared voice datapath.
REQ-013 SHALL have port: mix_out  output  10  unsigned sum of all serviced voice samples.
REQ-014 SHALL have port: mix_valid  output  1  one-cycle pulse when mix_out is updated.
REQ-015 SHALL have port: overrun  output  1  sticky flag, a sample_tick was dropped.

Function
REQ-016 Register map per voice SHALL be: reg 0 freq lo, reg 1 freq hi, reg 2 duration, reg 3 waveform, reg 4 attack, reg 5 sustain; regs 6-7 SHALL be reserved.
REQ-017 A write SHALL complete when wr_valid and wr_ready are both high on a rising edge, and the new value SHALL be visible from the next cycle.
REQ-018 Writes to voice index >= VOICES or to reg 6/7 SHALL be accepted and discarded with no state change.
REQ-019 A freq lo write SHALL load a per-voice staging byte only; a freq hi write SHALL commit {hi, staged lo} to the voice frequency atomically on the same edge.
REQ-020 FSM states SHALL be IDLE, SLOT(n) for n = 0..VOICES-1, and MIX.
REQ-021 IDLE -> SLOT(0) SHALL occur when sample_tick or the pending flag is high; a pending flag consumed this way SHALL clear.
REQ-022 Each SLOT(n) SHALL last exactly one cycle and SHALL drive voice_sel=n, voice_strobe=1 and bank n config on the config outputs.
REQ-023 voice_in SHALL be captured on the edge ending SLOT(n) and added into a 10-bit accumulator, which SHALL be cleared on entry to SLOT(0).
REQ-024 SLOT(VOICES-1) -> MIX; in MIX, mix_out SHALL load the accumulator and mix_valid SHALL be high for exactly that cycle; MIX -> IDLE.
REQ-025 Tick-to-mix_valid latency SHALL be VOICES+2 cycles when the tick arrives in IDLE.
REQ-026 wr_ready SHALL be 1 in IDLE and MIX and 0 in every SLOT state, so config is stable while serviced.
REQ-027 A sample_tick received outside IDLE SHALL set the one-deep pending flag; a sample_tick received while pending is already set SHALL be dropped and SHALL set overrun.
REQ-028 overrun SHALL clear only on reset.
REQ-029 Outside SLOT states, the config outputs and voice_sel SHALL hold their last driven values, and voice_strobe SHALL be 0.
REQ-030 If a write and a sample_tick coincide in IDLE, the write SHALL be accepted and SLOT(0) SHALL present the updated value.
REQ-031 The mix sum SHALL not overflow: the maximum is 4 x 255 = 1020, which fits in 10 bits.

Reset
REQ-032 While rst_n is low: all banks, staging bytes, accumulator and mix_out SHALL be 0; all config outputs, voice_sel, voice_strobe, mix_valid and overrun SHALL be 0; pending SHALL clear; FSM SHALL be IDLE; wr_ready SHALL be 1.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence immediately with no mix_valid pulse.

Verification
REQ-034 Write addr 0x00=0x34, then addr 0x01=0x12; tick -> in SLOT(0), frequency=0x1234.
REQ-035 Write addr 0x00=0x34 only; tick -> frequency stays 0x0000.
REQ-036 VOICES=3, voice_in returns 0xFF in every slot; tick at cycle t -> mix_valid at t+5 with mix_out=0x2FD; wr_ready=0 in cycles t+1 to t+3.
REQ-037 Tick, then tick at t+1, then tick at t+2 -> second sequence starts immediately after MIX; overrun=1 from t+3.
REQ-038 Write addr 0x1B (voice 3) with VOICES=3, and write addr 0x06 -> both accepted (wr_ready=1); no bank changes.
REQ-039 Assert rst_n low during SLOT(1) -> all outputs 0, no mix_valid; after release the next tick gives a normal sequence.
